// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB shadow state to generate stall,
// bubble, flush and forwarding controls for a five-stage in-order pipeline.
module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int CW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_multicycle,
  input  logic          branch_taken,
  output logic          pc_write_en,
  output logic          if_id_write_en,
  output logic          id_ex_bubble,
  output logic          ex_hold,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_ex_mem,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mc_busy,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
  } wstage_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
    logic          multicycle;
  } exstage_t;

  typedef enum logic [1:0] {
    MODE_ADV      = 2'd0,
    MODE_LOAD_USE = 2'd1,
    MODE_MC_HOLD  = 2'd2,
    MODE_FLUSH    = 2'd3
  } mode_e;

  localparam logic [3:0] MC_LAST = 4'(MC_LAT - 1);
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  exstage_t      ex_q, ex_d, id_ex_s;
  wstage_t       mem_q, mem_d, wb_q, wb_d;
  logic [3:0]    mc_cnt_q, mc_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          load_use_s, mc_hold_s;
  mode_e         mode_s;
  logic          unused_memread;

  // A producer in a later stage feeds an EX source; x0 is hard-wired and never forwards.
  function automatic logic src_hit(input wstage_t stg, input logic [AW-1:0] rs, input logic use_rs);
    return stg.valid & stg.regwrite & (stg.rd != '0) & (stg.rd == rs) & use_rs;
  endfunction

  function automatic wstage_t ex_to_w(input exstage_t e);
    wstage_t w;
    w.valid    = e.valid;
    w.rd       = e.rd;
    w.regwrite = e.regwrite;
    w.memread  = e.memread;
    return w;
  endfunction

  // Hazard detection and priority resolution
  always_comb begin
    load_use_s = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                 ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    mc_hold_s  = ex_q.valid & ex_q.multicycle & (mc_cnt_q != MC_LAST);
    if (branch_taken) begin
      mode_s = MODE_FLUSH;
    end else if (mc_hold_s) begin
      mode_s = MODE_MC_HOLD;
    end else if (load_use_s) begin
      mode_s = MODE_LOAD_USE;
    end else begin
      mode_s = MODE_ADV;
    end
  end

  // ID fields captured into EX; an empty slot enters as an all-zero bubble
  always_comb begin
    id_ex_s = '0;
    if (id_valid) begin
      id_ex_s.valid      = 1'b1;
      id_ex_s.rd         = id_rd;
      id_ex_s.regwrite   = id_regwrite;
      id_ex_s.memread    = id_memread;
      id_ex_s.rs1        = id_rs1;
      id_ex_s.rs2        = id_rs2;
      id_ex_s.use_rs1    = id_use_rs1;
      id_ex_s.use_rs2    = id_use_rs2;
      id_ex_s.multicycle = id_multicycle;
    end else begin
      id_ex_s = '0;
    end
  end

  // Pipeline control outputs
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    ex_hold        = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    case (mode_s)
      MODE_FLUSH: begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
      MODE_MC_HOLD: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        ex_hold        = 1'b1;
      end
      MODE_LOAD_USE: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
      MODE_ADV: begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
      default: begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    endcase
    mc_busy = ex_q.valid & ex_q.multicycle;
  end

  // Operand forwarding; the younger MEM result wins over WB
  always_comb begin
    if (src_hit(mem_q, ex_q.rs1, ex_q.use_rs1)) begin
      fwd_a = FWD_MEM;
    end else if (src_hit(wb_q, ex_q.rs1, ex_q.use_rs1)) begin
      fwd_a = FWD_WB;
    end else begin
      fwd_a = FWD_RF;
    end
    if (src_hit(mem_q, ex_q.rs2, ex_q.use_rs2)) begin
      fwd_b = FWD_MEM;
    end else if (src_hit(wb_q, ex_q.rs2, ex_q.use_rs2)) begin
      fwd_b = FWD_WB;
    end else begin
      fwd_b = FWD_RF;
    end
  end

  // Shadow-stage next state
  always_comb begin
    ex_d     = ex_q;
    mem_d    = ex_to_w(ex_q);
    wb_d     = mem_q;
    mc_cnt_d = 4'd0;
    case (mode_s)
      MODE_FLUSH: begin
        ex_d  = '0;
        mem_d = '0;
      end
      MODE_MC_HOLD: begin
        ex_d     = ex_q;
        mem_d    = '0;
        mc_cnt_d = mc_cnt_q + 4'd1;
      end
      MODE_LOAD_USE: begin
        ex_d = '0;
      end
      MODE_ADV: begin
        ex_d = id_ex_s;
      end
      default: begin
        ex_d  = '0;
        mem_d = '0;
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    if (!pc_write_en && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((mode_s == MODE_FLUSH) && (flush_cnt_q != {CW{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CW'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers; reset abandons any resident op at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      mc_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Load flags are tracked past EX for visibility only.
  assign unused_memread = mem_q.memread ^ wb_q.memread;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width (2^AW architectural registers).
REQ-002 SHALL have parameter MC_LAT, default 4, number of EX-stage cycles a multi-cycle op occupies (legal 2..15).
REQ-003 SHALL have parameter CW, default 32, perf-counter width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_rs1, id_rs2  input  AW  ID source addresses.
REQ-008 id_use_rs1, id_use_rs2  input  1  ID instruction reads rs1/rs2.
REQ-009 id_rd  input  AW  ID destination.
REQ-010 id_regwrite, id_memread, id_multicycle  input  1  ID control: writes rd / is load / is multi-cycle op.
REQ-011 branch_taken  input  1  taken branch resolved in MEM this cycle.
REQ-012 pc_write_en, if_id_write_en  output  1  PC / IF-ID register enables.
REQ-013 id_ex_bubble  output  1  load zeros into ID/EX controls.
REQ-014 ex_hold  output  1  ID/EX must retain contents; EX/MEM gets bubble.
REQ-015 flush_if_id, flush_id_ex, flush_ex_mem  output  1  zero the named pipeline register.
REQ-016 fwd_a, fwd_b  output  2  ALU operand select for EX: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
REQ-017 mc_busy  output  1  multi-cycle op resident in EX.
REQ-018 stall_cnt, flush_cnt  output  CW  cycles stalled / flush events.

Function
REQ-019 SHALL keep shadow stages EX, MEM, WB, each {valid, rd, regwrite, memread}; EX also {rs1, rs2, use_rs1, use_rs2, multicycle}; plus mc_cnt (4 bits).
REQ-020 load_use SHALL = EX.valid & EX.memread & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
REQ-021 mc_hold SHALL = EX.valid & EX.multicycle & mc_cnt != MC_LAT-1.
REQ-022 Outputs SHALL be combinational from shadow state and current inputs; zero added latency.
REQ-023 Priority branch_taken > mc_hold > load_use > normal advance.
REQ-024 branch_taken: flush_* = 1, pc_write_en = if_id_write_en = 1, id_ex_bubble = ex_hold = 0; next edge EX<=bubble, MEM<=bubble, WB<=MEM, mc_cnt<=0; flush_cnt += 1.
REQ-025 mc_hold: pc_write_en = if_id_write_en = 0, ex_hold = 1; next edge EX kept, mc_cnt += 1, MEM<=bubble, WB<=MEM.
REQ-026 load_use (no mc_hold): pc_write_en = if_id_write_en = 0, id_ex_bubble = 1; next edge EX<=bubble, MEM<=EX, WB<=MEM.
REQ-027 Normal: enables 1, no bubble; next edge EX<=ID fields (valid=id_valid), MEM<=EX, WB<=MEM, mc_cnt<=0.
REQ-028 Multi-cycle op SHALL occupy EX exactly MC_LAT cycles, producing MC_LAT-1 stall cycles.
REQ-029 fwd_a SHALL be 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.use_rs1; else 01 if same test against WB; else 00; fwd_b identical on rs2; MEM beats WB.
REQ-030 Register 0 SHALL never cause a stall or forward.
REQ-031 mc_busy = EX.valid & EX.multicycle.
REQ-032 stall_cnt SHALL increment each cycle pc_write_en=0; both counters saturate at all-ones.
REQ-033 All outputs SHALL be 0 (fwd 00) when no shadow valid and id_valid=0, except pc_write_en = if_id_write_en = 1.

Reset
REQ-034 reset SHALL clear all shadow valid bits, mc_cnt, stall_cnt, flush_cnt immediately, independent of clk; asserted mid multi-cycle op, the op is abandoned and stalls drop same cycle.

Verification
REQ-035 Load x5 then add x6,x5,x7: one cycle pc_write_en=0, id_ex_bubble=1; add in EX two cycles later gets fwd_a=01; stall_cnt=1.
REQ-036 add x3,x1,x2 then sub x4,x3,x3: sub in EX sees fwd_a=fwd_b=10, no stall.
REQ-037 Back-to-back writes to x8 then consumer: fwd selects 10 (MEM priority), not 01.
REQ-038 MC_LAT=4 mul x9 followed by dependent add: ex_hold=1 for 3 cycles, mc_busy 4 cycles, add then gets fwd_a=10; stall_cnt=3.
REQ-039 branch_taken during mc_hold: all flush_*=1, ex_hold=0; next cycle mc_busy=0, flush_cnt=1.
REQ-040 Consumer of x0 after load to x0: no stall, fwd 00; reset pulse mid-stall returns all outputs to REQ-033 values asynchronously.
